mini_aes_dcu: RTL



---
 rtl/mini_aes_dcu.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/mini_aes_dcu.sv
// -----------------------------------------------------------------------------
// mini_aes_dcu -- nibble-serial Mini-AES decipher unit (16-bit block and key,
// two rounds). Ciphertext and key arrive one nibble per accepted handshake;
// the plaintext is computed over a fixed sequence of states and streamed back
// one nibble per cycle.
//
// Optional feature macro: DCU_KEY_CACHE_EN
//   When defined, adds input key_hold. If key_hold=1 on the first accepted
//   nibble of a block, key_in is ignored for that block and the key held
//   from the previous block is reused (0000 after reset).
//
// Parameter:
//   MSN_FIRST  1: first nibble in/out is p0 (bits 15:12); 0: first is p3.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   in_valid   data_in/key_in nibble valid (honoured only in LOAD)
//   data_in    ciphertext nibble
//   key_in     key nibble, same index as data_in
//   key_hold   reuse previous key for this block (DCU_KEY_CACHE_EN only)
//   in_ready   high only in LOAD
//   busy       high in every state except LOAD
//   out_valid  plaintext nibble valid
//   data_out   plaintext nibble, 0 whenever out_valid is low
// -----------------------------------------------------------------------------
module mini_aes_dcu #(
  parameter int MSN_FIRST = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [3:0] data_in,
  input  logic [3:0] key_in,
`ifdef DCU_KEY_CACHE_EN
  input  logic       key_hold,
`endif
  output logic       in_ready,
  output logic       busy,
  output logic       out_valid,
  output logic [3:0] data_out
);

  typedef enum logic [2:0] {S_LOAD, S_KEY, S_R2, S_R1, S_R0, S_OUT} state_t;

  state_t      state, state_nxt;
  logic [1:0]  cnt;
  logic [1:0]  idx;
  logic [15:0] st, k0, k1, k2;
  logic [15:0] k1_w;
  logic        take_key;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'hE; 4'h1: return 4'h4; 4'h2: return 4'hD; 4'h3: return 4'h1;
      4'h4: return 4'h2; 4'h5: return 4'hF; 4'h6: return 4'hB; 4'h7: return 4'h8;
      4'h8: return 4'h3; 4'h9: return 4'hA; 4'hA: return 4'h6; 4'hB: return 4'hC;
      4'hC: return 4'h5; 4'hD: return 4'h9; 4'hE: return 4'h0; default: return 4'h7;
    endcase
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'hE; 4'h1: return 4'h3; 4'h2: return 4'h4; 4'h3: return 4'h8;
      4'h4: return 4'h1; 4'h5: return 4'hC; 4'h6: return 4'hA; 4'h7: return 4'hF;
      4'h8: return 4'h7; 4'h9: return 4'hD; 4'hA: return 4'h9; 4'hB: return 4'h6;
      4'hC: return 4'hB; 4'hD: return 4'h2; 4'hE: return 4'h0; default: return 4'h5;
    endcase
  endfunction

  // Multiply by x in GF(2^4) mod x^4+x+1: shift, fold the carry back as 0011.
  function automatic logic [3:0] mul2(input logic [3:0] x);
    return {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
  endfunction

  function automatic logic [3:0] mul3(input logic [3:0] x);
    return mul2(x) ^ x;
  endfunction

  function automatic logic [7:0] mc_col(input logic [3:0] a, input logic [3:0] b);
    return {mul3(a) ^ mul2(b), mul2(a) ^ mul3(b)};
  endfunction

  function automatic logic [15:0] mix_cols(input logic [15:0] v);
    return {mc_col(v[15:12], v[11:8]), mc_col(v[7:4], v[3:0])};
  endfunction

  function automatic logic [15:0] inv_sub(input logic [15:0] v);
    return {inv_sbox(v[15:12]), inv_sbox(v[11:8]), inv_sbox(v[7:4]), inv_sbox(v[3:0])};
  endfunction

  // Swap p1 and p3; its own inverse.
  function automatic logic [15:0] shift_rows(input logic [15:0] v);
    return {v[15:12], v[3:0], v[7:4], v[11:8]};
  endfunction

  // One key-schedule step: {w0..w3} -> {w4..w7} with round constant rc.
  function automatic logic [15:0] ks_next(input logic [15:0] w, input logic [3:0] rc);
    logic [3:0] a, b, c, d;
    a = w[15:12] ^ sbox(w[3:0]) ^ rc;
    b = w[11:8] ^ a;
    c = w[7:4] ^ b;
    d = w[3:0] ^ c;
    return {a, b, c, d};
  endfunction

  // Nibble index i selects p_i, where p0 occupies bits 15:12.
  function automatic logic [15:0] put_nib(input logic [15:0] v, input logic [1:0] i,
                                          input logic [3:0] n);
    case (i)
      2'd0:    v[15:12] = n;
      2'd1:    v[11:8]  = n;
      2'd2:    v[7:4]   = n;
      default: v[3:0]   = n;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] get_nib(input logic [15:0] v, input logic [1:0] i);
    case (i)
      2'd0:    return v[15:12];
      2'd1:    return v[11:8];
      2'd2:    return v[7:4];
      default: return v[3:0];
    endcase
  endfunction

  // The same counter walks the nibbles in LOAD and OUT; ~cnt gives 3-cnt.
  assign idx  = (MSN_FIRST != 0) ? cnt : ~cnt;
  assign k1_w = ks_next(k0, 4'h1);

`ifdef DCU_KEY_CACHE_EN
  logic hold_blk;
  // The first nibble decides for the whole block; later nibbles follow the latch.
  assign take_key = (cnt == 2'd0) ? !key_hold : !hold_blk;
`else
  assign take_key = 1'b1;
`endif

  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_LOAD;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    out_valid = 1'b0;
    data_out  = 4'h0;
    case (state)
      S_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid && cnt == 2'd3) state_nxt = S_KEY;
      end
      S_KEY: state_nxt = S_R2;
      S_R2:  state_nxt = S_R1;
      S_R1:  state_nxt = S_R0;
      S_R0:  state_nxt = S_OUT;
      S_OUT: begin
        out_valid = 1'b1;
        data_out  = get_nib(st, idx);
        if (cnt == 2'd3) state_nxt = S_LOAD;
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  // NOTE: the data and key registers are reset too: the held key must read
  // 0000 after reset, and an aborted block must not leak into the next one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 2'd0;
      st  <= 16'h0;
      k0  <= 16'h0;
      k1  <= 16'h0;
      k2  <= 16'h0;
`ifdef DCU_KEY_CACHE_EN
      hold_blk <= 1'b0;
`endif
    end else begin
      case (state)
        S_LOAD: if (in_valid) begin
          st  <= put_nib(st, idx, data_in);
          if (take_key) k0 <= put_nib(k0, idx, key_in);
          cnt <= cnt + 2'd1;
`ifdef DCU_KEY_CACHE_EN
          if (cnt == 2'd0) hold_blk <= key_hold;
`endif
        end
        S_KEY: begin
          k1 <= k1_w;
          k2 <= ks_next(k1_w, 4'h2);
        end
        S_R2:  st  <= shift_rows(inv_sub(st ^ k2));
        S_R1:  st  <= shift_rows(inv_sub(mix_cols(st ^ k1)));
        S_R0:  st  <= st ^ k0;
        S_OUT: cnt <= cnt + 2'd1;  // wraps to 0 on the last nibble
        default: ;
      endcase
    end
  end

endmodule
